// File: rtl/arb_pkg.sv
// Shared arbitration types and helpers used by the stream arbiters.
// Functions are sized for up to ARB_MAX_N channels; callers zero-extend and truncate.
package arb_pkg;

   localparam int ARB_MAX_N  = 64;
   localparam int ARB_MAX_SW = 6;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   function automatic logic [ARB_MAX_N-1:0] rr_pick(
      input logic [ARB_MAX_N-1:0]  valid,
      input logic [ARB_MAX_SW-1:0] ptr,
      input int                    n
   );
      logic [ARB_MAX_N-1:0] gnt;
      logic                 found;
      int                   c;
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < ARB_MAX_N; k++) begin
         if (k < n && !found) begin
            c = (int'(ptr) + k) % n;
            if (valid[ARB_MAX_SW'(c)]) begin
               gnt[ARB_MAX_SW'(c)] = 1'b1;
               found               = 1'b1;
            end
         end
      end
      return gnt;
   endfunction

   function automatic logic [ARB_MAX_SW-1:0] onehot2idx(input logic [ARB_MAX_N-1:0] oh);
      logic [ARB_MAX_SW-1:0] idx;
      idx = '0;
      for (int i = 0; i < ARB_MAX_N; i++) begin
         if (oh[i]) idx |= ARB_MAX_SW'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_stream_arbiter_if.sv
// Stream bundle between N producers, the round-robin arbiter and one consumer.
// master is the arbiter's view; slave is the surrounding environment's view.
interface rr_stream_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SW    = $clog2(N)
);
   logic [N-1:0]       in_valid;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_last;
   logic [N-1:0]       in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic               out_last;
   logic [SW-1:0]      out_src;
   logic               out_ready;
   logic [N-1:0]       grant;

   modport master (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, out_src, grant
   );

   modport slave (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_src, grant
   );
endinterface

// File: rtl/onehot_mux.sv
// One-hot AND-OR selector: dout is the din lane whose sel bit is set, zero if none.
// Purely combinational, no backpressure.
module onehot_mux #(
   parameter int WIDTH = 32,
   parameter int N     = 4
) (
   input  logic [N-1:0]       sel,
   input  logic [N*WIDTH-1:0] din,
   output logic [WIDTH-1:0]   dout
);
   always_comb begin
      dout = '0;
      for (int i = 0; i < N; i++) begin
         if (sel[i]) dout |= din[i*WIDTH +: WIDTH];
      end
   end
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate so ptr is bit 0, take lowest request, rotate back.
// Zero latency; all-zero grant when nothing requests.
module rr_pick #(
   parameter int N  = 4,
   parameter int SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [N-1:0]  gnt
);
   logic [N-1:0] rot;
   logic [N-1:0] pick;

   always_comb begin
      rot  = '0;
      pick = '0;
      gnt  = '0;
      for (int i = 0; i < N; i++) rot[i] = req[SW'(i) + ptr];
      for (int i = 0; i < N; i++) begin
         if (rot[i] && pick == '0) pick[i] = 1'b1;
      end
      for (int i = 0; i < N; i++) gnt[SW'(i) + ptr] = pick[i];
   end
endmodule

// File: rtl/rr_stream_arbiter.sv
// Packet-locked round-robin merge of N streams into one registered output; grant one edge after valid, data one edge later.
// in_ready is the held grant gated by output-register space, so a stalled output stops every input.
module rr_stream_arbiter #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SW    = $clog2(N)
) (
   input logic                 clk,
   input logic                 rst_n,
   rr_stream_arbiter_if.master bus
);
   typedef logic [arb_pkg::ARB_MAX_N-1:0] wide_t;

   arb_pkg::arb_state_t state_q, state_d;
   logic [N-1:0]           grant_q, grant_d;
   logic [N-1:0]           pick_gnt;
   logic [SW-1:0]          ptr_q, ptr_d;
   logic [SW-1:0]          pick_ptr;
   logic [SW-1:0]          gidx;
   logic [SW-1:0]          ptr_inc;
   logic                   adv;
   logic                   xfer;
   logic                   done;
   logic [N*(WIDTH+1)-1:0] mux_in;
   logic [WIDTH:0]         mux_out;

   assign adv          = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = grant_q & {N{adv}};
   assign bus.grant    = grant_q;
   assign xfer         = |(bus.in_valid & bus.in_ready);
   assign gidx         = SW'(arb_pkg::onehot2idx(wide_t'(grant_q)));
   assign ptr_inc      = gidx + SW'(1);
   assign done         = xfer && mux_out[WIDTH];

   // The finished channel sits last in the search order from ptr_inc, so it only wins when alone.
   assign pick_ptr = (state_q == arb_pkg::IDLE) ? ptr_q : ptr_inc;

   rr_pick #(.N(N), .SW(SW)) u_pick (
      .req (bus.in_valid),
      .ptr (pick_ptr),
      .gnt (pick_gnt)
   );

   for (genvar i = 0; i < N; i++) begin : g_pack
      assign mux_in[i*(WIDTH+1) +: WIDTH+1] = {bus.in_last[i], bus.in_data[i*WIDTH +: WIDTH]};
   end

   onehot_mux #(.WIDTH(WIDTH+1), .N(N)) u_mux (
      .sel  (grant_q),
      .din  (mux_in),
      .dout (mux_out)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         arb_pkg::IDLE: begin
            if (|bus.in_valid) begin
               state_d = arb_pkg::LOCK;
               grant_d = pick_gnt;
            end
         end
         arb_pkg::LOCK: begin
            if (done) begin
               ptr_d   = ptr_inc;
               grant_d = pick_gnt;
               if (pick_gnt == '0) state_d = arb_pkg::IDLE;
            end
         end
         default: begin
            state_d = arb_pkg::IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= arb_pkg::IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
         bus.out_src   <= '0;
      end else if (xfer) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= mux_out[WIDTH-1:0];
         bus.out_last  <= mux_out[WIDTH];
         bus.out_src   <= gidx;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule
